rc4_prga_decrypt: RTL and testbench



---
 rtl/rc4_pkg.sv | 33 +++
 rtl/rc4_prga_decrypt.sv | 202 ++++++++++++++++++++
 tb/tb_rc4_prga_decrypt.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 PRGA/decrypt stage.
//   state_t        : one-hot FSM encoding, IDLE/DONE plus the 13 per-byte states
//   CHAR_*         : bounds of the accepted plaintext alphabet (space, 'a'..'z')
//   is_valid_char  : 1 when a plaintext byte belongs to that alphabet
package rc4_pkg;

    typedef enum logic [14:0] {
        IDLE  = 15'h0001,
        RD_SI = 15'h0002,
        WT_SI = 15'h0004,
        LD_SI = 15'h0008,
        RD_SJ = 15'h0010,
        WT_SJ = 15'h0020,
        LD_SJ = 15'h0040,
        WR_I  = 15'h0080,
        WR_J  = 15'h0100,
        RD_F  = 15'h0200,
        WT_F  = 15'h0400,
        LD_F  = 15'h0800,
        WR_D  = 15'h1000,
        NEXT  = 15'h2000,
        DONE  = 15'h4000
    } state_t;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_LO    = 8'h61;
    localparam logic [7:0] CHAR_HI    = 8'h7A;

    function automatic logic is_valid_char(input logic [7:0] c);
        return (c == CHAR_SPACE) || ((c >= CHAR_LO) && (c <= CHAR_HI));
    endfunction

endpackage

// File: rtl/rc4_prga_decrypt.sv
// RC4 keystream generation and decryption. Walks the PRGA over the S memory,
// XORs each keystream byte with the encrypted ROM and writes the plaintext to
// the decrypted RAM, tracking whether every plaintext byte is in the alphabet.
// Ports:
//   clk, reset (async, active-low), start (sampled in IDLE only)
//   s_q / s_address / s_data / s_wen          : S memory port
//   enc_q / enc_address                       : encrypted message ROM
//   dec_address / dec_data / dec_wen          : decrypted message RAM
//   finish    : one-cycle pulse in DONE
//   key_valid : level, cleared on start, loaded with the valid flag at DONE
// Memories have two cycles of read latency: an address driven in state X
// yields data that is captured at the clock edge ending X+2.
module rc4_prga_decrypt
    import rc4_pkg::*;
#(
    parameter int unsigned MSG_LEN          = 32,
    parameter bit          ABORT_ON_INVALID = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] s_q,
    output logic [7:0] s_address,
    output logic [7:0] s_data,
    output logic       s_wen,
    input  logic [7:0] enc_q,
    output logic [7:0] enc_address,
    output logic [7:0] dec_address,
    output logic [7:0] dec_data,
    output logic       dec_wen,
    output logic       finish,
    output logic       key_valid
);

    localparam logic [7:0] LAST_K = 8'(MSG_LEN - 1);

    state_t     state_q, state_d;
    logic [7:0] i_q, i_d, j_q, j_d, k_q, k_d;
    logic [7:0] si_q, si_d, sj_q, sj_d, f_q, f_d, e_q, e_d;
    logic       valid_q, valid_d;

    logic [7:0] s_address_q, s_address_d, s_data_q, s_data_d;
    logic       s_wen_q, s_wen_d;
    logic [7:0] enc_address_q, enc_address_d;
    logic [7:0] dec_address_q, dec_address_d, dec_data_q, dec_data_d;
    logic       dec_wen_q, dec_wen_d;
    logic       finish_q, finish_d;
    logic       key_valid_q, key_valid_d;

    always_comb begin
        state_d       = state_q;
        i_d           = i_q;
        j_d           = j_q;
        k_d           = k_q;
        si_d          = si_q;
        sj_d          = sj_q;
        f_d           = f_q;
        e_d           = e_q;
        valid_d       = valid_q;
        key_valid_d   = key_valid_q;
        s_address_d   = s_address_q;
        s_data_d      = s_data_q;
        s_wen_d       = 1'b0;
        enc_address_d = enc_address_q;
        dec_address_d = dec_address_q;
        dec_data_d    = dec_data_q;
        dec_wen_d     = 1'b0;
        finish_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    i_d         = 8'd1;
                    j_d         = '0;
                    k_d         = '0;
                    valid_d     = 1'b1;
                    key_valid_d = 1'b0;
                    state_d     = RD_SI;
                end
            end
            RD_SI: state_d = WT_SI;
            WT_SI: state_d = LD_SI;
            LD_SI: begin
                si_d    = s_q;
                j_d     = j_q + s_q;
                state_d = RD_SJ;
            end
            RD_SJ: state_d = WT_SJ;
            WT_SJ: state_d = LD_SJ;
            LD_SJ: begin
                sj_d    = s_q;
                state_d = WR_I;
            end
            WR_I:  state_d = WR_J;
            WR_J:  state_d = RD_F;
            RD_F:  state_d = WT_F;
            WT_F:  state_d = LD_F;
            LD_F: begin
                f_d     = s_q;
                e_d     = enc_q;
                state_d = WR_D;
            end
            WR_D: begin
                if (!is_valid_char(f_q ^ e_q)) valid_d = 1'b0;
                state_d = NEXT;
            end
            NEXT: begin
                if ((k_q == LAST_K) || (ABORT_ON_INVALID && !valid_q)) begin
                    key_valid_d = valid_q;
                    state_d     = DONE;
                end else begin
                    i_d     = i_q + 8'd1;
                    k_d     = k_q + 8'd1;
                    state_d = RD_SI;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered: derive them from the state being entered and
        // the register values that state will see, so they are Moore in it.
        case (state_d)
            RD_SI: s_address_d = i_d;
            RD_SJ: s_address_d = j_d;
            WR_I: begin
                s_address_d = i_d;
                s_data_d    = sj_d;
                s_wen_d     = 1'b1;
            end
            WR_J: begin
                s_address_d = j_d;
                s_data_d    = si_d;
                s_wen_d     = 1'b1;
            end
            RD_F: begin
                s_address_d   = si_d + sj_d;
                enc_address_d = k_d;
            end
            WR_D: begin
                dec_address_d = k_d;
                dec_data_d    = f_d ^ e_d;
                dec_wen_d     = 1'b1;
            end
            DONE:    finish_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            i_q           <= '0;
            j_q           <= '0;
            k_q           <= '0;
            si_q          <= '0;
            sj_q          <= '0;
            f_q           <= '0;
            e_q           <= '0;
            valid_q       <= 1'b0;
            key_valid_q   <= 1'b0;
            s_address_q   <= '0;
            s_data_q      <= '0;
            s_wen_q       <= 1'b0;
            enc_address_q <= '0;
            dec_address_q <= '0;
            dec_data_q    <= '0;
            dec_wen_q     <= 1'b0;
            finish_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            i_q           <= i_d;
            j_q           <= j_d;
            k_q           <= k_d;
            si_q          <= si_d;
            sj_q          <= sj_d;
            f_q           <= f_d;
            e_q           <= e_d;
            valid_q       <= valid_d;
            key_valid_q   <= key_valid_d;
            s_address_q   <= s_address_d;
            s_data_q      <= s_data_d;
            s_wen_q       <= s_wen_d;
            enc_address_q <= enc_address_d;
            dec_address_q <= dec_address_d;
            dec_data_q    <= dec_data_d;
            dec_wen_q     <= dec_wen_d;
            finish_q      <= finish_d;
        end
    end

    assign s_address   = s_address_q;
    assign s_data      = s_data_q;
    assign s_wen       = s_wen_q;
    assign enc_address = enc_address_q;
    assign dec_address = dec_address_q;
    assign dec_data    = dec_data_q;
    assign dec_wen     = dec_wen_q;
    assign finish      = finish_q;
    assign key_valid   = key_valid_q;

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Bench for rc4_prga_decrypt. Three instances: 32-byte with abort, 32-byte
// without abort, 256-byte. Each has an S memory, an encrypted ROM and a
// decrypted RAM with two cycles of read latency, loaded one word per cycle.
module tb_rc4_prga_decrypt;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n [3];
    logic       start [3];
    logic [7:0] s_q [3], s_address [3], s_data [3];
    logic       s_wen [3];
    logic [7:0] enc_q [3], enc_address [3];
    logic [7:0] dec_address [3], dec_data [3];
    logic       dec_wen [3], finish [3], key_valid [3];

    logic [7:0] smem [3][256];
    logic [7:0] emem [3][256];
    logic [7:0] dmem [3][256];
    logic [7:0] s_p1 [3], e_p1 [3];

    logic       ld_en [3];
    logic [7:0] ld_addr, ld_s, ld_e;

    logic [7:0] img_s [256], img_e [256];
    logic [7:0] s_ksa [256], ks32 [256];
    logic [7:0] ms [256], mks [256];
    logic [7:0] snap [256];
    logic [7:0] snap_addr;
    logic [7:0] exp2 [32];

    int    n_checks = 0;
    int    n_fail   = 0;
    string pt = "the quick brown fox jumps over a";

    rc4_prga_decrypt #(.MSG_LEN(32), .ABORT_ON_INVALID(1'b1)) dut0 (
        .clk(clk), .reset(rst_n[0]), .start(start[0]),
        .s_q(s_q[0]), .s_address(s_address[0]), .s_data(s_data[0]), .s_wen(s_wen[0]),
        .enc_q(enc_q[0]), .enc_address(enc_address[0]),
        .dec_address(dec_address[0]), .dec_data(dec_data[0]), .dec_wen(dec_wen[0]),
        .finish(finish[0]), .key_valid(key_valid[0]));

    rc4_prga_decrypt #(.MSG_LEN(32), .ABORT_ON_INVALID(1'b0)) dut1 (
        .clk(clk), .reset(rst_n[1]), .start(start[1]),
        .s_q(s_q[1]), .s_address(s_address[1]), .s_data(s_data[1]), .s_wen(s_wen[1]),
        .enc_q(enc_q[1]), .enc_address(enc_address[1]),
        .dec_address(dec_address[1]), .dec_data(dec_data[1]), .dec_wen(dec_wen[1]),
        .finish(finish[1]), .key_valid(key_valid[1]));

    rc4_prga_decrypt #(.MSG_LEN(256), .ABORT_ON_INVALID(1'b1)) dut2 (
        .clk(clk), .reset(rst_n[2]), .start(start[2]),
        .s_q(s_q[2]), .s_address(s_address[2]), .s_data(s_data[2]), .s_wen(s_wen[2]),
        .enc_q(enc_q[2]), .enc_address(enc_address[2]),
        .dec_address(dec_address[2]), .dec_data(dec_data[2]), .dec_wen(dec_wen[2]),
        .finish(finish[2]), .key_valid(key_valid[2]));

    always @(posedge clk) begin
        s_p1[0] <= smem[0][s_address[0]];   s_q[0]   <= s_p1[0];
        e_p1[0] <= emem[0][enc_address[0]]; enc_q[0] <= e_p1[0];
        s_p1[1] <= smem[1][s_address[1]];   s_q[1]   <= s_p1[1];
        e_p1[1] <= emem[1][enc_address[1]]; enc_q[1] <= e_p1[1];
        s_p1[2] <= smem[2][s_address[2]];   s_q[2]   <= s_p1[2];
        e_p1[2] <= emem[2][enc_address[2]]; enc_q[2] <= e_p1[2];
        if (ld_en[0]) begin
            smem[0][ld_addr] <= ld_s; emem[0][ld_addr] <= ld_e; dmem[0][ld_addr] <= 8'hEE;
        end else begin
            if (s_wen[0])   smem[0][s_address[0]]   <= s_data[0];
            if (dec_wen[0]) dmem[0][dec_address[0]] <= dec_data[0];
        end
        if (ld_en[1]) begin
            smem[1][ld_addr] <= ld_s; emem[1][ld_addr] <= ld_e; dmem[1][ld_addr] <= 8'hEE;
        end else begin
            if (s_wen[1])   smem[1][s_address[1]]   <= s_data[1];
            if (dec_wen[1]) dmem[1][dec_address[1]] <= dec_data[1];
        end
        if (ld_en[2]) begin
            smem[2][ld_addr] <= ld_s; emem[2][ld_addr] <= ld_e; dmem[2][ld_addr] <= 8'hEE;
        end else begin
            if (s_wen[2])   smem[2][s_address[2]]   <= s_data[2];
            if (dec_wen[2]) dmem[2][dec_address[2]] <= dec_data[2];
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic ok_char(input logic [7:0] c);
        return (c == 8'h20) || (c >= 8'h61 && c <= 8'h7A);
    endfunction

    function automatic logic [7:0] pt256(input int k);
        return ((k % 27) == 26) ? 8'h20 : 8'(8'h61 + (k % 27));
    endfunction

    function automatic logic [63:0] outs(input int u);
        return {20'd0, s_address[u], s_data[u], enc_address[u], dec_address[u],
                dec_data[u], s_wen[u], dec_wen[u], finish[u], key_valid[u]};
    endfunction

    // Reference RC4 key schedule for key 00 00 03
    function automatic void model_ksa();
        int         j = 0;
        logic [7:0] t;
        logic [7:0] key [3];
        key = '{8'h00, 8'h00, 8'h03};
        for (int n = 0; n < 256; n++) ms[n] = 8'(n);
        for (int n = 0; n < 256; n++) begin
            j = (j + int'(ms[n]) + int'(key[n % 3])) % 256;
            t = ms[n]; ms[n] = ms[j]; ms[j] = t;
        end
    endfunction

    // Reference RC4 PRGA over ms, fresh i/j, keystream into mks
    function automatic void model_prga(input int len);
        int         mi = 0;
        int         mj = 0;
        logic [7:0] t;
        for (int k = 0; k < len; k++) begin
            mi = (mi + 1) % 256;
            mj = (mj + int'(ms[mi])) % 256;
            t = ms[mi]; ms[mi] = ms[mj]; ms[mj] = t;
            mks[k] = ms[(int'(ms[mi]) + int'(ms[mj])) % 256];
        end
    endfunction

    task automatic load_mem(input int u);
        for (int n = 0; n < 256; n++) begin
            @(negedge clk);
            ld_addr = 8'(n); ld_s = img_s[n]; ld_e = img_e[n]; ld_en[u] = 1'b1;
        end
        @(negedge clk);
        ld_en[u] = 1'b0;
    endtask

    // Pulse start; returns the cycle finish is seen in (start sampled in cycle 0)
    task automatic do_run(input int u, input int budget, input int snap_at,
                          output int fin_cyc, output logic [7:0] first_addr);
        int cnt;
        fin_cyc = -1;
        @(negedge clk); start[u] = 1'b1;
        @(posedge clk); #1; start[u] = 1'b0;
        cnt = 1;
        first_addr = s_address[u];
        while (cnt < budget && fin_cyc < 0) begin
            @(posedge clk); #1; cnt++;
            if (cnt == snap_at) begin
                for (int n = 0; n < 256; n++) snap[n] = smem[u][n];
                snap_addr = s_address[u];
            end
            if (finish[u]) fin_cyc = cnt;
        end
    endtask

    task automatic set_full_vector();
        for (int n = 0; n < 256; n++) begin
            img_s[n] = s_ksa[n];
            img_e[n] = (n < 32) ? (ks32[n] ^ 8'(pt[n])) : 8'h00;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got time limit, expected summary before it");
        $fatal(1, "watchdog");
    end

    initial begin
        int         fin, cnt, fcount, f1, f2;
        logic [7:0] fa;
        logic       kv1, kv2, kv_mid, fin_after1, fin_after2, v2;

        for (int u = 0; u < 3; u++) begin
            rst_n[u] = 1'b0; start[u] = 1'b0; ld_en[u] = 1'b0;
        end
        ld_addr = '0; ld_s = '0; ld_e = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_outs0", outs(0), 64'd0);
        check_eq("rst_outs1", outs(1), 64'd0);
        check_eq("rst_outs2", outs(2), 64'd0);
        check_eq("rst_state", 64'(dut0.state_q), 64'(rc4_pkg::IDLE));
        for (int u = 0; u < 3; u++) rst_n[u] = 1'b1;

        // Identity S, hand-computed first bytes; byte 2 decrypts to 07 and aborts
        for (int n = 0; n < 256; n++) begin img_s[n] = 8'(n); img_e[n] = 8'h00; end
        img_e[0] = 8'h63; img_e[1] = 8'h66;
        load_mem(0);
        do_run(0, 200, 26, fin, fa);
        check_eq("id_first_addr", 64'(fa), 64'd1);
        check_eq("id_dec0", 64'(dmem[0][0]), 64'h61);
        check_eq("id_dec1", 64'(dmem[0][1]), 64'h63);
        check_eq("id_s1_ieqj", 64'(snap[1]), 64'd1);
        check_eq("id_s2", 64'(snap[2]), 64'd3);
        check_eq("id_s3", 64'(snap[3]), 64'd2);
        check_eq("id_dec2", 64'(dmem[0][2]), 64'h07);
        check_eq("id_dec3_untouched", 64'(dmem[0][3]), 64'hEE);
        check_eq("id_fin_cycle", 64'(fin), 64'd40);
        check_eq("id_key_valid", 64'(key_valid[0]), 64'd0);

        model_ksa();
        for (int n = 0; n < 256; n++) s_ksa[n] = ms[n];
        model_prga(32);
        for (int n = 0; n < 256; n++) ks32[n] = mks[n];

        // Full all-valid 32-byte vector
        set_full_vector();
        load_mem(0);
        do_run(0, 600, 0, fin, fa);
        check_eq("full_fin_cycle", 64'(fin), 64'd417);
        check_eq("full_key_valid", 64'(key_valid[0]), 64'd1);
        for (int k = 0; k < 32; k++)
            check_eq($sformatf("full_dec%0d", k), 64'(dmem[0][k]), 64'(8'(pt[k])));

        // Reset during WR_J of byte 10 (cycle 138)
        load_mem(0);
        @(negedge clk); start[0] = 1'b1;
        @(posedge clk); #1; start[0] = 1'b0;
        cnt = 1;
        while (cnt < 138) begin @(posedge clk); #1; cnt++; end
        check_eq("mid_wen_before", 64'(s_wen[0]), 64'd1);
        rst_n[0] = 1'b0;
        #1;
        check_eq("mid_outs_zero", outs(0), 64'd0);
        check_eq("mid_state_idle", 64'(dut0.state_q), 64'(rc4_pkg::IDLE));
        fcount = 0;
        repeat (10) begin @(posedge clk); #1; if (finish[0]) fcount++; end
        @(negedge clk); rst_n[0] = 1'b1;
        repeat (10) begin @(posedge clk); #1; if (finish[0]) fcount++; end
        check_eq("mid_no_finish", 64'(fcount), 64'd0);
        load_mem(0);
        do_run(0, 600, 0, fin, fa);
        check_eq("rerun_first_addr", 64'(fa), 64'd1);
        check_eq("rerun_fin_cycle", 64'(fin), 64'd417);
        check_eq("rerun_key_valid", 64'(key_valid[0]), 64'd1);
        for (int k = 0; k < 32; k++)
            check_eq($sformatf("rerun_dec%0d", k), 64'(dmem[0][k]), 64'(8'(pt[k])));

        // Byte 5 corrupted to 'A', abort enabled
        set_full_vector();
        img_e[5] = ks32[5] ^ 8'h41;
        load_mem(0);
        do_run(0, 600, 0, fin, fa);
        check_eq("abort_fin_cycle", 64'(fin), 64'd79);
        check_eq("abort_key_valid", 64'(key_valid[0]), 64'd0);
        for (int k = 0; k < 5; k++)
            check_eq($sformatf("abort_dec%0d", k), 64'(dmem[0][k]), 64'(8'(pt[k])));
        check_eq("abort_dec5", 64'(dmem[0][5]), 64'h41);
        check_eq("abort_dec6_untouched", 64'(dmem[0][6]), 64'hEE);

        // Same corruption, abort disabled
        load_mem(1);
        do_run(1, 600, 0, fin, fa);
        check_eq("noab_fin_cycle", 64'(fin), 64'd417);
        check_eq("noab_key_valid", 64'(key_valid[1]), 64'd0);
        for (int k = 0; k < 32; k++)
            check_eq($sformatf("noab_dec%0d", k), 64'(dmem[1][k]),
                     (k == 5) ? 64'h41 : 64'(8'(pt[k])));

        // start held high: two back-to-back runs; the second runs on the permuted S
        set_full_vector();
        load_mem(1);
        model_ksa(); model_prga(32); model_prga(32);
        v2 = 1'b1;
        for (int k = 0; k < 32; k++) begin
            exp2[k] = mks[k] ^ img_e[k];
            if (!ok_char(exp2[k])) v2 = 1'b0;
        end
        f1 = -1; f2 = -1; kv1 = 1'bx; kv2 = 1'bx; kv_mid = 1'bx;
        fin_after1 = 1'bx; fin_after2 = 1'bx;
        @(negedge clk); start[1] = 1'b1;
        @(posedge clk); #1;
        cnt = 1;
        while (cnt < 1000 && f2 < 0) begin
            @(posedge clk); #1; cnt++;
            if (cnt == f1 + 1) fin_after1 = finish[1];
            if (cnt == 420) start[1] = 1'b0;
            if (cnt == 500) kv_mid = key_valid[1];
            if (finish[1]) begin
                if (f1 < 0) begin f1 = cnt; kv1 = key_valid[1]; end
                else if (cnt != f1 + 1) begin f2 = cnt; kv2 = key_valid[1]; end
            end
        end
        @(posedge clk); #1; fin_after2 = finish[1];
        check_eq("b2b_fin1_cycle", 64'(f1), 64'd417);
        check_eq("b2b_fin1_width", 64'(fin_after1), 64'd0);
        check_eq("b2b_kv1", 64'(kv1), 64'd1);
        check_eq("b2b_kv_mid_cleared", 64'(kv_mid), 64'd0);
        check_eq("b2b_fin2_cycle", 64'(f2), 64'd835);
        check_eq("b2b_fin2_width", 64'(fin_after2), 64'd0);
        check_eq("b2b_kv2", 64'(kv2), 64'(v2));
        for (int k = 0; k < 32; k++)
            check_eq($sformatf("b2b_dec%0d", k), 64'(dmem[1][k]), 64'(exp2[k]));

        // 256-byte run: i wraps to 0 on the last byte
        model_ksa(); model_prga(256);
        for (int n = 0; n < 256; n++) begin
            img_s[n] = s_ksa[n];
            img_e[n] = mks[n] ^ pt256(n);
        end
        load_mem(2);
        do_run(2, 3500, 3316, fin, fa);
        check_eq("l256_i_wrap", 64'(snap_addr), 64'd0);
        check_eq("l256_fin_cycle", 64'(fin), 64'd3329);
        check_eq("l256_key_valid", 64'(key_valid[2]), 64'd1);
        for (int k = 0; k < 256; k++)
            check_eq($sformatf("l256_dec%0d", k), 64'(dmem[2][k]), 64'(pt256(k)));
        for (int n = 0; n < 256; n++)
            check_eq($sformatf("l256_s%0d", n), 64'(smem[2][n]), 64'(ms[n]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
